// File: rtl/rs_dvbt_pkg.sv
// ---------------------------------------------------------------------------
// rs_dvbt_pkg
// Shared constants and types for the DVB-T RS(204,188) framing logic.
//   N / K           : codeword and message length in bytes
//   IDX_W           : width of a byte index within a codeword
//   SYNC_BYTE       : normal transport-stream sync byte
//   SYNC_BYTE_INV   : inverted sync byte (first packet of a scrambler group)
//   lock_state_e    : alignment FSM states
// ---------------------------------------------------------------------------
package rs_dvbt_pkg;

  localparam int N     = 204;
  localparam int K     = 188;
  localparam int IDX_W = $clog2(N);

  localparam logic [7:0] SYNC_BYTE     = 8'h47;
  localparam logic [7:0] SYNC_BYTE_INV = ~SYNC_BYTE;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } lock_state_e;

  // Either polarity of the sync byte counts as a hit.
  function automatic logic is_sync(input logic [7:0] b);
    return (b == SYNC_BYTE) || (b == SYNC_BYTE_INV);
  endfunction

endpackage

// File: rtl/rs_token_delay.sv
// ---------------------------------------------------------------------------
// rs_token_delay
// DEPTH x WIDTH shift-register delay line, shifted every clock, cleared by
// a synchronous active-high reset. Models the fixed pipeline latency of a
// free-running downstream block so per-byte tokens line up with its output.
// Ports:
//   Clk   in          clock
//   Reset in          synchronous, active-high reset
//   din   in  WIDTH   token entering the line
//   dout  out WIDTH   token entered DEPTH clocks earlier
// ---------------------------------------------------------------------------
module rs_token_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;
  logic [DEPTH-1:0][WIDTH-1:0] pipe_d;

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/rs_frame_controller.sv
// ---------------------------------------------------------------------------
// rs_frame_controller
// Acquires RS(204,188) codeword alignment from transport-stream sync bytes,
// forwards aligned bytes to the RS decoder with a start-of-codeword strobe,
// and marks the K message bytes of each decoded codeword once they emerge
// from the decoder's fixed-latency pipeline.
//
// Ports:
//   Clk, Reset             clock, synchronous active-high reset
//   in_byte/in_valid       byte stream from the outer deinterleaver
//   dec_byte/valid/sop     aligned bytes to the decoder (1 clock latency)
//   dec_msg                decoder output, DEC_LATENCY clocks after dec_byte
//   out_byte/valid/sop/eop decoded message bytes (parity bytes suppressed)
//   locked                 high while in LOCK
// Optional (macro RS_FRAME_CTRL_STATS_EN):
//   loss_events[15:0]      saturating count of LOCK->HUNT transitions
//   cw_count[31:0]         saturating count of codewords sent to the decoder
//
// state  | meaning
// HUNT   | searching for any sync byte, nothing forwarded
// VERIFY | candidate alignment, counting sync matches at index 0
// LOCK   | aligned, every valid byte forwarded; counting sync misses
// ---------------------------------------------------------------------------
module rs_frame_controller
  import rs_dvbt_pkg::*;
#(
  parameter int DEC_LATENCY = 408,
  parameter int LOCK_CNT    = 3,
  parameter int LOSS_CNT    = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic [7:0]  dec_byte,
  output logic        dec_valid,
  output logic        dec_sop,
  input  logic [7:0]  dec_msg,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        locked
`ifdef RS_FRAME_CTRL_STATS_EN
  ,
  output logic [15:0] loss_events,
  output logic [31:0] cw_count
`endif
);

  // match holds 0..LOCK_CNT-1 and miss holds 0..LOSS_CNT-1; the final
  // increment is replaced by the state change.
  localparam int MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int MISS_W  = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

  lock_state_e        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [7:0]         dec_byte_q, dec_byte_d;
  logic               dec_valid_q, dec_valid_d;
  logic               dec_sop_q, dec_sop_d;
  logic               locked_q, locked_d;

  logic [IDX_W-1:0]   oidx_q, oidx_d;
  logic [7:0]         out_byte_q, out_byte_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;

  logic               sync_hit;
  logic               idx_zero;
  logic [IDX_W-1:0]   idx_next;
  logic               fwd;
  logic [1:0]         dly_tok;
  logic               dly_valid;
  logic               dly_sop;
  logic [IDX_W-1:0]   oidx_eff;

  assign sync_hit = is_sync(in_byte);
  assign idx_zero = (idx_q == '0);
  assign idx_next = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;

  // -------------------------------------------------------------------------
  // Alignment FSM and decoder-side forwarding
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    match_d = match_q;
    miss_d  = miss_q;
    fwd     = 1'b0;

    case (state_q)
      HUNT: begin
        // idx is held at 0 throughout HUNT, so a direct entry into LOCK
        // forwards this sync byte as the codeword start.
        if (in_valid && sync_hit) begin
          idx_d  = IDX_W'(1);
          miss_d = '0;
          if (LOCK_CNT == 1) begin
            state_d = LOCK;
            match_d = '0;
            fwd     = 1'b1;
          end else begin
            state_d = VERIFY;
            match_d = MATCH_W'(1);
          end
        end
      end

      VERIFY: begin
        if (in_valid) begin
          idx_d = idx_next;
          if (idx_zero) begin
            if (sync_hit) begin
              if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                // The locking sync byte starts the first forwarded codeword.
                state_d = LOCK;
                match_d = '0;
                miss_d  = '0;
                fwd     = 1'b1;
              end else begin
                match_d = match_q + 1'b1;
              end
            end else begin
              state_d = HUNT;
              match_d = '0;
              idx_d   = '0;
            end
          end
        end
      end

      LOCK: begin
        if (in_valid) begin
          idx_d = idx_next;
          fwd   = 1'b1;
          if (idx_zero) begin
            if (sync_hit) begin
              miss_d = '0;
            end else if (miss_q == MISS_W'(LOSS_CNT - 1)) begin
              // Drop without forwarding so the decoder never starts a
              // codeword it will not receive in full.
              state_d = HUNT;
              miss_d  = '0;
              idx_d   = '0;
              fwd     = 1'b0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = HUNT;
        idx_d   = '0;
        match_d = '0;
        miss_d  = '0;
      end
    endcase

    dec_valid_d = fwd;
    dec_sop_d   = fwd && idx_zero;
    dec_byte_d  = fwd ? in_byte : dec_byte_q;
    locked_d    = (state_d == LOCK);
  end

  // -------------------------------------------------------------------------
  // Token delay matching the decoder pipeline
  // -------------------------------------------------------------------------
  rs_token_delay #(
    .DEPTH (DEC_LATENCY),
    .WIDTH (2)
  ) u_token_delay (
    .Clk   (Clk),
    .Reset (Reset),
    .din   ({dec_valid_q, dec_sop_q}),
    .dout  (dly_tok)
  );

  assign dly_valid = dly_tok[1];
  assign dly_sop   = dly_tok[0];

  // -------------------------------------------------------------------------
  // Output framing. A delayed sop always restarts the index, even if the
  // previous codeword was cut short; oidx saturates at K so long gaps
  // without a sop can never wrap back into the message range.
  // -------------------------------------------------------------------------
  always_comb begin
    oidx_eff    = dly_sop ? '0 : oidx_q;
    out_valid_d = dly_valid && (oidx_eff < IDX_W'(K));
    out_sop_d   = dly_valid && dly_sop;
    out_eop_d   = dly_valid && (oidx_eff == IDX_W'(K - 1));
    out_byte_d  = dec_msg;
    oidx_d      = out_valid_d ? oidx_eff + 1'b1 : oidx_eff;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= HUNT;
      idx_q       <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      dec_byte_q  <= '0;
      dec_valid_q <= 1'b0;
      dec_sop_q   <= 1'b0;
      locked_q    <= 1'b0;
      oidx_q      <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      dec_byte_q  <= dec_byte_d;
      dec_valid_q <= dec_valid_d;
      dec_sop_q   <= dec_sop_d;
      locked_q    <= locked_d;
      oidx_q      <= oidx_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign dec_byte  = dec_byte_q;
  assign dec_valid = dec_valid_q;
  assign dec_sop   = dec_sop_q;
  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign locked    = locked_q;

`ifdef RS_FRAME_CTRL_STATS_EN
  // -------------------------------------------------------------------------
  // Saturating statistics
  // -------------------------------------------------------------------------
  logic [15:0] loss_events_q, loss_events_d;
  logic [31:0] cw_count_q, cw_count_d;

  always_comb begin
    loss_events_d = loss_events_q;
    cw_count_d    = cw_count_q;
    if ((state_q == LOCK) && (state_d == HUNT) && (loss_events_q != '1)) begin
      loss_events_d = loss_events_q + 16'd1;
    end
    if (dec_sop_d && (cw_count_q != '1)) begin
      cw_count_d = cw_count_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      loss_events_q <= '0;
      cw_count_q    <= '0;
    end else begin
      loss_events_q <= loss_events_d;
      cw_count_q    <= cw_count_d;
    end
  end

  assign loss_events = loss_events_q;
  assign cw_count    = cw_count_q;
`endif

endmodule

// File: doc/rs_frame_controller.md
Name: rs_frame_controller

Overview:
- Sequences the RS(204,188) decoder in the DVB-T receiver chain.
- Acquires codeword alignment from the 0x47/0xB8 transport-stream sync bytes and forwards aligned bytes to the decoder with a start-of-codeword strobe.
- Tracks the decoder's fixed pipeline latency and marks the 188 message bytes of each decoded codeword with valid/sop/eop.
- Sits between the outer deinterleaver output and the RS_Decoder/descrambler.

Parameters:
- N, 204, codeword length in bytes.
- K, 188, message bytes per codeword.
- DEC_LATENCY, 408, clocks from a byte entering the decoder to its decoded byte leaving it; must be at least 1.
- LOCK_CNT, 3, consecutive sync matches needed to declare lock.
- LOSS_CNT, 3, consecutive sync misses in LOCK that drop to HUNT.
- SYNC_BYTE, 8'h47, normal sync byte. Inverted sync is ~SYNC_BYTE (8'hB8).

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- in_byte  in  8  byte from upstream.
- in_valid  in  1  in_byte qualifier.
- dec_byte  out  8  byte to RS_Decoder msg_in.
- dec_valid  out  1  dec_byte carries a locked codeword byte.
- dec_sop  out  1  first byte (index 0) of a codeword to the decoder.
- dec_msg  in  8  RS_Decoder msg_out.
- out_byte  out  8  decoded byte (registered dec_msg).
- out_valid  out  1  out_byte is a message byte (index 0..K-1).
- out_sop  out  1  message byte index 0.
- out_eop  out  1  message byte index K-1.
- locked  out  1  high in LOCK state.

Behaviour:
- Reset is synchronous and active-high on Clk.
  - All outputs are 0 after reset; state is HUNT.
  - Counters and the delay line are cleared.
  - Reset mid-codeword discards all in-flight tokens; out_valid stays 0 until fresh tokens emerge.
- Byte index counter idx:
  - Range 0..N-1; advances only on in_valid.
  - Wraps from N-1 to 0.
  - A sync hit is in_byte equal to SYNC_BYTE or ~SYNC_BYTE.
- HUNT:
  - On a valid sync hit: idx<=1, match<=1, go to VERIFY.
  - No bytes are forwarded.
- VERIFY:
  - At a valid byte with idx==0:
    - hit: match++; if match+1==LOCK_CNT go to LOCK.
    - miss: go to HUNT, match<=0.
  - With LOCK_CNT=1, the first hit goes straight to LOCK.
  - Sync hits at idx!=0 are ignored.
- LOCK:
  - Every valid byte is forwarded: dec_byte<=in_byte, dec_valid<=1, dec_sop<=(idx==0). This is 1 clock of register latency.
  - At idx==0: a hit clears miss; a miss does miss++.
  - When miss reaches LOSS_CNT, go to HUNT. The byte that causes loss is not forwarded, so the decoder never sees a partial codeword.
  - When in_valid=0: dec_valid=0, dec_sop=0, and dec_byte holds its value.
- Entry to LOCK:
  - The transition happens on the idx==0 sync byte.
  - That same byte is forwarded as dec_sop, so the first codeword is complete.
- Delay line:
  - DEC_LATENCY-deep shift register of {dec_valid, dec_sop}, shifted every clock.
  - The decoder is a free-running pipeline with no enable, so gaps are preserved.
- Output index oidx:
  - Reset to 0 on a delayed sop; incremented on each delayed valid.
  - out_valid = delayed valid AND oidx<K.
  - out_sop when oidx==0; out_eop when oidx==K-1.
  - Bytes K..N-1 (parity) are suppressed.
  - out_byte registers dec_msg aligned with these flags.
- Simultaneous events:
  - If a delayed sop arrives while oidx<K (truncated codeword), the new sop wins. Set oidx=0; no out_eop is issued for the truncated codeword.
- locked is registered and equals (state==LOCK).

Optional Feature:
- Macro: RS_FRAME_CTRL_STATS_EN.
- When defined, adds two outputs:
  - loss_events[15:0]: increments on each LOCK->HUNT transition.
  - cw_count[31:0]: increments on each dec_sop.
  - Both saturate at their maximum value and clear on Reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package rs_dvbt_pkg holds:
  - N, K, SYNC_BYTE and the inverted sync constant.
  - Lock-state enum: HUNT, VERIFY, LOCK.
- One sub-module: rs_token_delay. It is a parameterized DEPTH x WIDTH shift-register delay line with synchronous reset, used for the {valid,sop} tokens.

Test Plan:
- Clean stream, DEC_LATENCY=4, with 4 packets 0x47 + 203 bytes:
  - locked rises on the 3rd sync byte; dec_sop is 1 on that byte.
  - Exactly 188 out_valid per forwarded codeword, starting 4+1 clocks after dec_sop; out_eop on the 188th.
- False sync 0x47 at index 50 while in HUNT, true syncs elsewhere:
  - VERIFY fails at index 0 of the false alignment, returns to HUNT, then locks on the true alignment.
- In LOCK, corrupt sync to 0x00 in 2 consecutive packets, then restore:
  - locked stays 1 and the miss count clears.
  - Corrupting 3 consecutive syncs makes locked fall at the 3rd; that byte has no dec_valid.
- Sync 0xB8 every 8th packet:
  - Treated as a hit; lock is maintained; out_byte index 0 equals dec_msg at that point.
- in_valid toggling 1/0 every clock:
  - dec_valid follows the pattern, out_valid reproduces the same gaps after DEC_LATENCY+1, and idx advances only on valid bytes.
- Reset asserted for 1 clock mid-codeword in LOCK:
  - Next clock: all outputs 0, locked=0, no out_valid until relock plus latency.
  - With STATS_EN defined, loss_events=0 after reset and cw_count counts codewords.
